pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
Receiving end of the divide-by-2 clock/reset generator. The generator produces pixClk and a short power-on reset pulse; this block consumes both in the clkRef domain.
- Qualifies the reset pulse and checks the expected toggle-every-cycle pattern.
- Emits a single-cycle pixel enable, a lock flag and a clean downstream reset for the VGA timing logic.

Parameters:
SYNC_STAGES, 2, synchronizer flops on pixClkIn and rstIn (minimum 2)
MIN_RST_CYCLES, 3, minimum rstIn high length accepted as a valid reset pulse
LOCK_CYCLES, 16, consecutive good toggles required before locked
CNT_W, 8, width of glitchCount (saturating)

Ports:
clkRef  input  1  reference clock, all logic posedge
reset  input  1  synchronous active-high reset
pixClkIn  input  1  divided clock from generator, sampled as data
rstIn  input  1  reset pulse from generator
pixEn  output  1  1-cycle pulse on each rising edge of the synchronized pixClkIn, gated by locked
locked  output  1  pattern qualified
rstPix  output  1  active-high reset to downstream pixel logic
fault  output  1  pattern violation detected
glitchCount  output  CNT_W  saturating count of toggle violations since reset

Behaviour:
- Interface: reset is synchronous, active-high; clock is clkRef.
- Reset values (on reset): pixEn=0, locked=0, rstPix=1, fault=0, glitchCount=0, state=IDLE, synchronizer flops=0, counters=0.
- Synchronization:
  - pixClkIn and rstIn each pass through SYNC_STAGES flops, giving ps and rs.
  - psPrev holds ps from the previous cycle.
  - A violation ("viol") is ps==psPrev.
- States:
  - IDLE: wait for rs=1, then go to HOLD with rstCnt=1.
  - HOLD: rstCnt increments while rs=1.
    - On rs falling with rstCnt>=MIN_RST_CYCLES: go to TRAIN with goodCnt=0.
    - On rs falling with rstCnt<MIN_RST_CYCLES: runt pulse; go to IDLE and increment glitchCount.
  - TRAIN:
    - No viol: goodCnt increments.
    - viol: goodCnt clears to 0 and glitchCount increments.
    - When goodCnt reaches LOCK_CYCLES-1 with no viol in the same cycle: go to LOCKED.
    - rs=1: go to HOLD (rstCnt=1).
  - LOCKED:
    - locked=1, rstPix=0.
    - viol: go to FAULT and increment glitchCount.
    - rs=1: go to HOLD (re-reset by generator). locked and rstPix update the next cycle.
  - FAULT: fault=1, locked=0, rstPix=1. Exit depends on STICKY_FAULT_EN.
- Output timing: locked and rstPix are registered, decoded from the next-state. locked rises on the same edge the state becomes LOCKED.
- pixEn: registered; pixEn=1 in the cycle after ps rises (ps=1, psPrev=0) while the state is LOCKED. It is never asserted in any other state.
- Latency: from the rstIn falling edge at the pin to locked=1 is SYNC_STAGES+LOCK_CYCLES clkRef cycles, given a clean toggle.
- glitchCount saturates at all-ones; no wrap.
- Simultaneous events:
  - rs=1 takes priority over viol in TRAIN and LOCKED.
  - External reset overrides everything on any cycle, including mid-train.

Optional Feature:
STICKY_FAULT_EN
- Defined: FAULT is terminal until reset. fault stays high and rs is ignored.
- Undefined: FAULT goes to HOLD on rs=1 and fault clears on that transition. If rs=0, FAULT stays in FAULT.

Decomposition:
- Shared package pll_mon_pkg:
  - State enum: IDLE, HOLD, TRAIN, LOCKED, FAULT (3-bit).
  - Default constants for LOCK_CYCLES and MIN_RST_CYCLES.
- Sub-module sync_ff: parameterised SYNC_STAGES flop chain, instantiated twice (once for pixClkIn, once for rstIn).

Test Plan:
- Clean startup: reset for 2 cycles, rstIn high 4 cycles, then pixClkIn toggling every cycle -> locked=1 exactly 18 cycles after rstIn falls (SYNC_STAGES=2, LOCK_CYCLES=16), rstPix=0, pixEn pulses every 2nd cycle, glitchCount=0.
- Runt reset: rstIn high 2 cycles -> state returns to IDLE, glitchCount=1, locked stays 0.
- Training glitch: after a valid reset, hold pixClkIn static for 1 cycle at good toggle 10 -> goodCnt restarts, locked is delayed by 11 cycles, glitchCount=1.
- Locked fault: once locked, hold pixClkIn for 2 cycles -> fault=1, locked=0, rstPix=1 and pixEn=0 on the next cycle. Without STICKY_FAULT_EN, a new 4-cycle rstIn pulse re-locks. With the macro defined, fault remains 1 until reset.
- Re-reset while locked: rstIn high 3 cycles during LOCKED -> locked drops and re-qualifies with no fault asserted.
- Saturation: generate 300 runt pulses with CNT_W=8 -> glitchCount holds at 255.

Source files
------------

// File: rtl/pll_mon_pkg.sv
// Shared types and defaults for the PLL lock monitor.
// The only state encoding and default constants used by pll_lock_monitor live here.
package pll_mon_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        TRAIN  = 3'd2,
        LOCKED = 3'd3,
        FAULT  = 3'd4
    } pllState_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_MIN_RST_CYCLES = 3;
    localparam int DEF_LOCK_CYCLES    = 16;
    localparam int DEF_CNT_W          = 8;

    // Bits needed to hold values 0..maxVal (at least one bit).
    function automatic int cntBits(input int maxVal);
        return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/pll_lock_monitor_if.sv
// Signal bundle between the clock/reset generator side and the lock monitor.
// master = generator/consumer side, slave = pll_lock_monitor.
interface pll_lock_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             pixClkIn;
    logic             rstIn;
    logic             pixEn;
    logic             locked;
    logic             rstPix;
    logic             fault;
    logic [CNT_W-1:0] glitchCount;

    modport master (
        output pixClkIn, rstIn,
        input  pixEn, locked, rstPix, fault, glitchCount
    );

    modport slave (
        input  pixClkIn, rstIn,
        output pixEn, locked, rstPix, fault, glitchCount
    );
endinterface

// File: rtl/pll_lock_monitor_sync_ff.sv
// Plain flop-chain synchronizer; STAGES must be at least 2.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clkRef,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the chain.
    always_ff @(posedge clkRef) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/pll_lock_monitor.sv
// PLL / divided-clock lock monitor, clkRef domain.
// Optional build macro: STICKY_FAULT_EN (FAULT is terminal until reset).
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a reset pulse from the generator
//   HOLD   | reset pulse active, measuring its length
//   TRAIN  | counting consecutive good pixClk toggles
//   LOCKED | pattern qualified, downstream released
//   FAULT  | toggle violation seen while locked
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic               clkRef,
    input  logic               reset,
    pll_lock_monitor_if.slave  mon
);
    localparam int RST_W  = cntBits(MIN_RST_CYCLES);
    localparam int GOOD_W = cntBits(LOCK_CYCLES - 1);
    localparam logic [RST_W-1:0]  RST_MIN   = RST_W'(MIN_RST_CYCLES);
    localparam logic [RST_W-1:0]  RST_ONE   = RST_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CYCLES - 1);

    logic ps, rs, psPrev, viol;
    pllState_t state, stateNext;
    logic [RST_W-1:0]  rstCnt, rstCntNext;
    logic [GOOD_W-1:0] goodCnt, goodCntNext, goodInc;
    logic [CNT_W-1:0]  glitchCount;
    logic glitchInc;
    logic lockedD, rstPixD, faultD, pixEnD;
    logic lockedQ, rstPixQ, faultQ, pixEnQ;

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncPix (
        .clkRef (clkRef),
        .reset  (reset),
        .d      (mon.pixClkIn),
        .q      (ps)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) uSyncRst (
        .clkRef (clkRef),
        .reset  (reset),
        .d      (mon.rstIn),
        .q      (rs)
    );

    assign viol    = (ps == psPrev);
    assign goodInc = goodCnt + 1'b1;

    // State, counter and previous-sample registers.
    always_ff @(posedge clkRef) begin
        if (reset) begin
            state   <= IDLE;
            rstCnt  <= '0;
            goodCnt <= '0;
            psPrev  <= 1'b0;
        end else begin
            state   <= stateNext;
            rstCnt  <= rstCntNext;
            goodCnt <= goodCntNext;
            psPrev  <= ps;
        end
    end

    // Next-state and counter update; rs outranks viol in TRAIN and LOCKED.
    always_comb begin
        stateNext   = state;
        rstCntNext  = rstCnt;
        goodCntNext = goodCnt;
        glitchInc   = 1'b0;
        case (state)
            IDLE: begin
                if (rs) begin
                    stateNext  = HOLD;
                    rstCntNext = RST_ONE;
                end
            end
            HOLD: begin
                if (rs) begin
                    // Saturate at the minimum; only the threshold matters.
                    if (rstCnt < RST_MIN) rstCntNext = rstCnt + 1'b1;
                end else if (rstCnt >= RST_MIN) begin
                    stateNext   = TRAIN;
                    goodCntNext = '0;
                end else begin
                    stateNext = IDLE;
                    glitchInc = 1'b1;
                end
            end
            TRAIN: begin
                if (rs) begin
                    stateNext  = HOLD;
                    rstCntNext = RST_ONE;
                end else if (viol) begin
                    goodCntNext = '0;
                    glitchInc   = 1'b1;
                end else begin
                    goodCntNext = goodInc;
                    if (goodInc == GOOD_LAST) stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if (rs) begin
                    stateNext  = HOLD;
                    rstCntNext = RST_ONE;
                end else if (viol) begin
                    stateNext = FAULT;
                    glitchInc = 1'b1;
                end
            end
            FAULT: begin
`ifdef STICKY_FAULT_EN
                stateNext = FAULT;
`else
                if (rs) begin
                    stateNext  = HOLD;
                    rstCntNext = RST_ONE;
                end
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output decode from the next state so flags change on the transition edge.
    always_comb begin
        lockedD = (stateNext == LOCKED);
        rstPixD = (stateNext != LOCKED);
        faultD  = (stateNext == FAULT);
        pixEnD  = (state == LOCKED) && (stateNext == LOCKED) && ps && !psPrev;
    end

    // Registered outputs.
    always_ff @(posedge clkRef) begin
        if (reset) begin
            lockedQ <= 1'b0;
            rstPixQ <= 1'b1;
            faultQ  <= 1'b0;
            pixEnQ  <= 1'b0;
        end else begin
            lockedQ <= lockedD;
            rstPixQ <= rstPixD;
            faultQ  <= faultD;
            pixEnQ  <= pixEnD;
        end
    end

    // Saturating violation counter.
    always_ff @(posedge clkRef) begin
        if (reset)                                glitchCount <= '0;
        else if (glitchInc && (glitchCount != '1)) glitchCount <= glitchCount + 1'b1;
    end

    assign mon.pixEn       = pixEnQ;
    assign mon.locked      = lockedQ;
    assign mon.rstPix      = rstPixQ;
    assign mon.fault       = faultQ;
    assign mon.glitchCount = glitchCount;
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor (SYNC_STAGES=2, MIN_RST_CYCLES=3, LOCK_CYCLES=16, CNT_W=8).
module tb_pll_lock_monitor;
    import pll_mon_pkg::*;

    logic clkRef;
    logic reset;
    bit   tog;
    int   checks;
    int   failures;
    int   pixOnes;
    logic pixLast;
    int   pixAlt;

    pll_lock_monitor_if #(.CNT_W(8)) mon ();

    pll_lock_monitor #(
        .SYNC_STAGES    (2),
        .MIN_RST_CYCLES (3),
        .LOCK_CYCLES    (16),
        .CNT_W          (8)
    ) dut (
        .clkRef (clkRef),
        .reset  (reset),
        .mon    (mon)
    );

    initial clkRef = 1'b0;
    always #5 clkRef = ~clkRef;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clkRef edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clkRef);
        #1;
        if (tog) mon.pixClkIn = ~mon.pixClkIn;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // rstIn high for n cycles; returns just after the edge where it falls.
    task automatic pulseRst(input int n);
        mon.rstIn = 1'b1;
        repeat (n) tick();
        mon.rstIn = 1'b0;
    endtask

    // Expect locked to rise exactly 18 edges after rstIn fell.
    task automatic checkLockAt(input string tag);
        repeat (17) tick();
        check({tag, "_before"}, 32'(mon.locked), 32'd0);
        tick();
        check({tag, "_at18"}, 32'(mon.locked), 32'd1);
    endtask

    task automatic runt();
        pulseRst(2);
        repeat (4) tick();
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        tog          = 1'b1;
        reset        = 1'b0;
        mon.pixClkIn = 1'b0;
        mon.rstIn    = 1'b0;

        // Reset values
        doReset(2);
        check("rst_pixEn", 32'(mon.pixEn), 32'd0);
        check("rst_locked", 32'(mon.locked), 32'd0);
        check("rst_rstPix", 32'(mon.rstPix), 32'd1);
        check("rst_fault", 32'(mon.fault), 32'd0);
        check("rst_glitch", 32'(mon.glitchCount), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));

        // Clean startup
        repeat (3) tick();
        pulseRst(4);
        checkLockAt("startup");
        check("startup_rstPix", 32'(mon.rstPix), 32'd0);
        check("startup_glitch", 32'(mon.glitchCount), 32'd0);
        pixOnes = 0;
        pixAlt  = 0;
        pixLast = mon.pixEn;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (mon.pixEn === 1'b1) pixOnes++;
            if (mon.pixEn !== pixLast) pixAlt++;
            pixLast = mon.pixEn;
        end
        check("pixEn_ones", 32'(pixOnes), 32'd4);
        check("pixEn_alternate", 32'(pixAlt), 32'd8);

        // Locked fault: pixClkIn held for two cycles
        tog = 1'b0;
        tick();
        tick();
        tog = 1'b1;
        tick();
        check("fault_early", 32'(mon.fault), 32'd0);
        tick();
        check("fault_set", 32'(mon.fault), 32'd1);
        check("fault_locked", 32'(mon.locked), 32'd0);
        check("fault_rstPix", 32'(mon.rstPix), 32'd1);
        check("fault_pixEn", 32'(mon.pixEn), 32'd0);
        check("fault_glitch", 32'(mon.glitchCount), 32'd1);
        repeat (3) tick();
`ifdef STICKY_FAULT_EN
        pulseRst(4);
        repeat (20) tick();
        check("sticky_fault", 32'(mon.fault), 32'd1);
        check("sticky_locked", 32'(mon.locked), 32'd0);
        check("sticky_rstPix", 32'(mon.rstPix), 32'd1);
`else
        pulseRst(4);
        checkLockAt("relock");
        check("relock_fault", 32'(mon.fault), 32'd0);
`endif

        // Re-reset while locked
        doReset(2);
        repeat (3) tick();
        pulseRst(4);
        checkLockAt("prelock");
        repeat (4) tick();
        pulseRst(3);
        check("rereset_drop", 32'(mon.locked), 32'd0);
        check("rereset_fault", 32'(mon.fault), 32'd0);
        checkLockAt("rereset");
        check("rereset_fault_end", 32'(mon.fault), 32'd0);

        // Training glitch at good toggle 10
        doReset(2);
        repeat (3) tick();
        pulseRst(4);
        repeat (10) tick();
        tog = 1'b0;
        tick();
        tog = 1'b1;
        repeat (16) tick();
        check("train_normal_slot", 32'(mon.locked), 32'd0);
        tick();
        check("train_before", 32'(mon.locked), 32'd0);
        tick();
        check("train_delayed", 32'(mon.locked), 32'd1);
        check("train_glitch", 32'(mon.glitchCount), 32'd1);

        // Runt reset pulse
        doReset(2);
        repeat (3) tick();
        runt();
        check("runt_state", 32'(dut.state), 32'(IDLE));
        check("runt_glitch", 32'(mon.glitchCount), 32'd1);
        check("runt_locked", 32'(mon.locked), 32'd0);

        // External reset in the middle of training
        doReset(2);
        repeat (3) tick();
        pulseRst(4);
        repeat (10) tick();
        doReset(1);
        check("midtrain_state", 32'(dut.state), 32'(IDLE));
        repeat (25) tick();
        check("midtrain_locked", 32'(mon.locked), 32'd0);
        check("midtrain_rstPix", 32'(mon.rstPix), 32'd1);

        // glitchCount saturation
        doReset(2);
        repeat (3) tick();
        repeat (254) runt();
        check("sat_254", 32'(mon.glitchCount), 32'd254);
        runt();
        check("sat_255", 32'(mon.glitchCount), 32'd255);
        repeat (45) runt();
        check("sat_hold", 32'(mon.glitchCount), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
